// File: rtl/dmem_pkg.sv
// Shared types and sizing for the data-memory controller.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEPTH_DEF = 256;
   localparam int IDX_W     = 8;
   localparam int CNT_W     = 4;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: synchronous write, asynchronous read.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic             clock,
   input  logic             we,
   input  logic [IDX_W-1:0] widx,
   input  logic [31:0]      wdata,
   input  logic [IDX_W-1:0] ridx,
   output logic [31:0]      rdata
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [31:0] mem [DEPTH];

   // Word indices wrap modulo DEPTH so a smaller array still aliases cleanly.
   function automatic logic [AW-1:0] wrap(input logic [IDX_W-1:0] i);
      return AW'(32'(i) % 32'(DEPTH));
   endfunction

   // NOTE: storage has no reset; contents must survive a controller reset.
   always_ff @(posedge clock) begin
      if (we) mem[wrap(widx)] <= wdata;
   end

   assign rdata = mem[wrap(ridx)];

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller with configurable stall latency.
// Define DMEM_WBUF_EN to build in a one-entry posted write buffer.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int WAIT_CYCLES = 0,
   parameter int DEPTH       = DEPTH_DEF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        stall,
   output logic        misalign
);

   localparam logic [CNT_W-1:0] WAIT_M1 =
      CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             req, bad_align, ok, is_store, is_load;
   logic             fsm_req, fsm_stall, complete, st_stall;
   logic [IDX_W-1:0] idx;
   logic             arr_we;
   logic [IDX_W-1:0] arr_widx;
   logic [31:0]      arr_wdata, rdata, load_data;
   logic             unused_addr;

   assign req         = mem_read | mem_write;
   assign bad_align   = req & (addr[1:0] != 2'b00);
   assign ok          = req & ~bad_align;
   assign is_store    = ok & mem_write;
   assign is_load     = ok & mem_read & ~mem_write;
   assign idx         = addr[9:2];
   assign unused_addr = ^addr[31:10];

`ifdef DMEM_WBUF_EN
   logic             wb_valid, drain, capture;
   logic [IDX_W-1:0] wb_idx;
   logic [31:0]      wb_data;
   logic [CNT_W-1:0] wb_cnt;

   // Stores are posted into the buffer; only loads walk the latency FSM.
   assign fsm_req   = is_load;
   assign drain     = wb_valid & (wb_cnt == '0);
   assign st_stall  = is_store & wb_valid & ~drain;
   assign capture   = is_store & ~st_stall & ~reset;
   assign load_data = (wb_valid && wb_idx == idx) ? wb_data : rdata;
   assign arr_we    = drain & ~reset;
   assign arr_widx  = wb_idx;
   assign arr_wdata = wb_data;

   always_ff @(posedge clock) begin
      if (reset) begin
         wb_valid <= 1'b0;
         wb_cnt   <= '0;
      end else if (capture) begin
         wb_valid <= 1'b1;
         wb_idx   <= idx;
         wb_data  <= din;
         wb_cnt   <= WAIT_M1;
      end else if (drain) begin
         wb_valid <= 1'b0;
      end else if (wb_valid) begin
         wb_cnt   <= wb_cnt - 1'b1;
      end
   end
`else
   assign fsm_req   = ok;
   assign st_stall  = 1'b0;
   assign load_data = rdata;
   assign arr_we    = complete & is_store & ~reset;
   assign arr_widx  = idx;
   assign arr_wdata = din;
`endif

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // NOTE: every output is defaulted first so no path infers a latch.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      fsm_stall = 1'b0;
      complete  = 1'b0;
      case (state)
         IDLE: begin
            if (fsm_req) begin
               if (WAIT_CYCLES == 0) begin
                  complete = 1'b1;
               end else begin
                  fsm_stall = 1'b1;
                  if (WAIT_CYCLES == 1) begin
                     state_n = DONE;
                  end else begin
                     state_n = BUSY;
                     cnt_n   = WAIT_M1;
                  end
               end
            end
         end
         BUSY: begin
            if (!fsm_req) begin
               state_n = IDLE;
            end else begin
               fsm_stall = 1'b1;
               if (cnt == CNT_W'(1)) state_n = DONE;
               else                  cnt_n   = cnt - 1'b1;
            end
         end
         DONE: begin
            state_n  = IDLE;
            complete = fsm_req;
         end
         default: state_n = IDLE;
      endcase
   end

   assign stall    = ~reset & (fsm_stall | st_stall);
   assign misalign = ~reset & bad_align;
   assign dout     = (~reset & complete & is_load) ? load_data : 32'h0;

   dmem_array #(.DEPTH(DEPTH)) u_array (
      .clock (clock),
      .we    (arr_we),
      .widx  (arr_widx),
      .wdata (arr_wdata),
      .ridx  (idx),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: three instances with WAIT_CYCLES = 0, 3 and 2.
module tb_dmem_ctrl;

`ifdef DMEM_WBUF_EN
   localparam bit WB = 1'b1;
`else
   localparam bit WB = 1'b0;
`endif
   // Expected stall counts for stores, which differ when stores are posted.
   localparam int SW3 = WB ? 0 : 3;
   localparam int SW2 = WB ? 0 : 2;
   localparam int SB2 = WB ? 1 : 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        rd [3];
   logic        wr [3];
   logic [31:0] ad [3];
   logic [31:0] di [3];
   logic [31:0] dq [3];
   logic        st [3];
   logic        mis[3];

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   dmem_ctrl #(.WAIT_CYCLES(0)) u_w0 (
      .clock(clock), .reset(reset), .mem_read(rd[0]), .mem_write(wr[0]),
      .addr(ad[0]), .din(di[0]), .dout(dq[0]), .stall(st[0]), .misalign(mis[0]));
   dmem_ctrl #(.WAIT_CYCLES(3)) u_w3 (
      .clock(clock), .reset(reset), .mem_read(rd[1]), .mem_write(wr[1]),
      .addr(ad[1]), .din(di[1]), .dout(dq[1]), .stall(st[1]), .misalign(mis[1]));
   dmem_ctrl #(.WAIT_CYCLES(2)) u_w2 (
      .clock(clock), .reset(reset), .mem_read(rd[2]), .mem_write(wr[2]),
      .addr(ad[2]), .din(di[2]), .dout(dq[2]), .stall(st[2]), .misalign(mis[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input int k, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
      rd[k] = r;
      wr[k] = w;
      ad[k] = a;
      di[k] = d;
   endtask

   task automatic idle(input int k, input int n);
      drive(k, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (n) tick();
   endtask

   // Holds one request for stalls+1 cycles, checking stall/dout every cycle.
   task automatic access(input string tag, input int k, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         input int stalls, input logic [31:0] exp);
      drive(k, r, w, a, d);
      for (int i = 0; i <= stalls; i++) begin
         @(negedge clock);
         if (i < stalls) begin
            check({tag, ".stall"}, 32'(st[k]), 32'd1);
            check({tag, ".dout_wait"}, dq[k], 32'h0);
         end else begin
            check({tag, ".stall_end"}, 32'(st[k]), 32'd0);
            check({tag, ".dout"}, dq[k], exp);
         end
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      for (int k = 0; k < 3; k++) drive(k, 1'b1, 1'b0, 32'h9, 32'h0);
      @(negedge clock);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst%0d.stall", k), 32'(st[k]), 32'd0);
         check($sformatf("rst%0d.dout", k), dq[k], 32'h0);
         check($sformatf("rst%0d.mis", k), 32'(mis[k]), 32'd0);
      end
      tick();
      tick();
      reset = 1'b0;
      for (int k = 0; k < 3; k++) idle(k, 0);
      tick();

      // ---- WAIT_CYCLES = 0 ----
      access("w0.sw08", 0, 1'b0, 1'b1, 32'h08, 32'h12345678, 0, 32'h0);
      access("w0.lw08", 0, 1'b1, 1'b0, 32'h08, 32'h0, 0, 32'h12345678);
      access("w0.sw04", 0, 1'b0, 1'b1, 32'h04, 32'h11111111, 0, 32'h0);
      drive(0, 1'b0, 1'b1, 32'h06, 32'hDEADBEEF);
      @(negedge clock);
      check("w0.mis_sw.mis", 32'(mis[0]), 32'd1);
      check("w0.mis_sw.stall", 32'(st[0]), 32'd0);
      check("w0.mis_sw.dout", dq[0], 32'h0);
      tick();
      access("w0.lw04", 0, 1'b1, 1'b0, 32'h04, 32'h0, 0, 32'h11111111);
      drive(0, 1'b1, 1'b0, 32'h05, 32'h0);
      @(negedge clock);
      check("w0.mis_lw.mis", 32'(mis[0]), 32'd1);
      check("w0.mis_lw.dout", dq[0], 32'h0);
      tick();
      access("w0.rw0c", 0, 1'b1, 1'b1, 32'h0C, 32'h77, 0, 32'h0);
      access("w0.lw0c", 0, 1'b1, 1'b0, 32'h0C, 32'h0, 0, 32'h77);
      access("w0.lw408", 0, 1'b1, 1'b0, 32'h408, 32'h0, 0, 32'h12345678);
      drive(0, 1'b0, 1'b0, 32'h08, 32'h0);
      @(negedge clock);
      check("w0.idle.dout", dq[0], 32'h0);
      check("w0.idle.mis", 32'(mis[0]), 32'd0);
      idle(0, 2);

      // ---- WAIT_CYCLES = 3 ----
      access("w3.sw08", 1, 1'b0, 1'b1, 32'h08, 32'h12345678, SW3, 32'h0);
      idle(1, 4);
      access("w3.lw08", 1, 1'b1, 1'b0, 32'h08, 32'h0, 3, 32'h12345678);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clock);
      check("w3.after.dout", dq[1], 32'h0);
      check("w3.after.stall", 32'(st[1]), 32'd0);
      tick();
      // Request withdrawn mid-access, then a fresh access must see all stalls.
      drive(1, 1'b1, 1'b0, 32'h08, 32'h0);
      @(negedge clock);
      check("w3.drop.stall1", 32'(st[1]), 32'd1);
      tick();
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clock);
      check("w3.drop.stall", 32'(st[1]), 32'd0);
      check("w3.drop.dout", dq[1], 32'h0);
      tick();
      access("w3.relw08", 1, 1'b1, 1'b0, 32'h08, 32'h0, 3, 32'h12345678);
      access("w3.sw0c", 1, 1'b0, 1'b1, 32'h0C, 32'hCAFE0000, SW3, 32'h0);
      idle(1, 4);
      drive(1, 1'b0, 1'b1, 32'h0C, 32'h55);
      @(negedge clock);
      check("w3.abort.start", 32'(st[1]), WB ? 32'd0 : 32'd1);
      tick();
      reset = 1'b1;
      @(negedge clock);
      check("w3.abort.rst_stall", 32'(st[1]), 32'd0);
      check("w3.abort.rst_dout", dq[1], 32'h0);
      tick();
      reset = 1'b0;
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clock);
      check("w3.abort.post_stall", 32'(st[1]), 32'd0);
      tick();
      access("w3.lw0c", 1, 1'b1, 1'b0, 32'h0C, 32'h0, 3, 32'hCAFE0000);
      idle(1, 2);

      // ---- WAIT_CYCLES = 2 ----
      access("w2.sw10", 2, 1'b0, 1'b1, 32'h10, 32'hA, SW2, 32'h0);
      access("w2.lw10", 2, 1'b1, 1'b0, 32'h10, 32'h0, 2, 32'hA);
      idle(2, 3);
      access("w2.sw14", 2, 1'b0, 1'b1, 32'h14, 32'hB1, SW2, 32'h0);
      access("w2.sw18", 2, 1'b0, 1'b1, 32'h18, 32'hB2, SB2, 32'h0);
      idle(2, 4);
      access("w2.lw14", 2, 1'b1, 1'b0, 32'h14, 32'h0, 2, 32'hB1);
      access("w2.lw18", 2, 1'b1, 1'b0, 32'h18, 32'h0, 2, 32'hB2);
      idle(2, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
